// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: sequencer state encoding and default widths.
package rv32i_pkg;

    localparam int INSTRET_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I instruction sequencer: steps fetch/decode/exec/mem/wb,
// arbitrates the shared memory port and counts retired instructions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | parked, waiting for run
// FETCH  | instruction fetch on the shared memory port
// DECODE | control_unit decodes IR; illegal opcode traps
// EXEC   | ALU cycle; loads/stores continue to MEM
// MEM    | data access; a store retires on its accepting cycle
// WB     | register write-back, PC update, retire
// TRAP   | sticky illegal-instruction halt, left only by reset
module multicycle_sequencer
    import rv32i_pkg::*;
#(
    parameter int INSTRET_W = INSTRET_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 load,
    input  logic                 store,
    input  logic                 reg_write,
    input  logic                 illegal,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_fetch,
    output logic                 ir_en,
    output logic                 pc_en,
    output logic                 rf_we,
    output logic                 trap,
    output logic                 busy,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_fetch = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        rf_we     = 1'b0;
        trap      = 1'b0;
        retire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req   = 1'b1;
                mem_fetch = 1'b1;
                if (mem_ready) begin
                    ir_en   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = (load || store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                // load+store together behaves as a store: it retires here, no rd write
                mem_req = 1'b1;
                mem_we  = store;
                if (mem_ready) begin
                    if (store) begin
                        pc_en   = 1'b1;
                        retire  = 1'b1;
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = reg_write;
                pc_en   = 1'b1;
                retire  = 1'b1;
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; a second instance
// with a 4-bit counter shares all inputs to exercise instret wrap.
module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, load = 1'b0, store = 1'b0, reg_write = 1'b0;
    logic illegal = 1'b0, mem_ready = 1'b0;

    logic mem_req, mem_we, mem_fetch, ir_en, pc_en, rf_we, trap, busy;
    logic [2:0]  state;
    logic [31:0] instret;

    logic mem_req4, mem_we4, mem_fetch4, ir_en4, pc_en4, rf_we4, trap4, busy4;
    logic [2:0] state4;
    logic [3:0] instret4;

    logic [10:0] obs;
    assign obs = {state, mem_req, mem_we, mem_fetch, ir_en, pc_en, rf_we, trap, busy};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .load(load), .store(store),
        .reg_write(reg_write), .illegal(illegal), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_fetch(mem_fetch), .ir_en(ir_en),
        .pc_en(pc_en), .rf_we(rf_we), .trap(trap), .busy(busy), .state(state),
        .instret(instret)
    );

    multicycle_sequencer #(.INSTRET_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run), .load(load), .store(store),
        .reg_write(reg_write), .illegal(illegal), .mem_ready(mem_ready),
        .mem_req(mem_req4), .mem_we(mem_we4), .mem_fetch(mem_fetch4), .ir_en(ir_en4),
        .pc_en(pc_en4), .rf_we(rf_we4), .trap(trap4), .busy(busy4), .state(state4),
        .instret(instret4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // row = {run,load,store,reg_write,illegal,mem_ready, state, outs}
    // outs = {mem_req,mem_we,mem_fetch,ir_en,pc_en,rf_we,trap,busy}

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        #1;
        total++;
        if (obs !== 11'd0) begin
            bad++; $display("FAIL reset_outs: got %b want %b", obs, 11'd0);
        end
        total++;
        if (instret !== 32'd0) begin
            bad++; $display("FAIL reset_instret: got %0d want 0", instret);
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        #1;
        total++;
        if (obs !== {3'd1, 8'b1010_0001}) begin
            bad++; $display("FAIL reset_release_fetch: got %b want %b", obs, {3'd1, 8'b1010_0001});
        end
        run = 1'b0;
        rst_n = 1'b0;
        tick();
        mem_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        total++;
        if (obs !== 11'd0) begin
            bad++; $display("FAIL reset_mid_fetch: got %b want %b", obs, 11'd0);
        end
        tick();
        total++;
        if (obs !== 11'd0) begin
            bad++; $display("FAIL reset_ready_ignored: got %b want %b", obs, 11'd0);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_alu();
        logic [16:0] tbl [6] = '{
            {6'b100000, 3'd0, 8'b0000_0000},
            {6'b100101, 3'd1, 8'b1011_0001},
            {6'b000101, 3'd2, 8'b0000_0001},
            {6'b000101, 3'd3, 8'b0000_0001},
            {6'b000100, 3'd5, 8'b0000_1101},
            {6'b000000, 3'd0, 8'b0000_0000}
        };
        logic [31:0] n0 = instret;
        for (int i = 0; i < 6; i++) begin
            {run, load, store, reg_write, illegal, mem_ready} = tbl[i][16:11];
            #1;
            total++;
            if (obs !== tbl[i][10:0]) begin
                bad++; $display("FAIL alu row %0d: got %b want %b", i, obs, tbl[i][10:0]);
            end
            tick();
        end
        total++;
        if (instret !== n0 + 32'd1) begin
            bad++; $display("FAIL alu_instret: got %0d want %0d", instret, n0 + 32'd1);
        end
    endtask

    task automatic test_load();
        logic [16:0] tbl [9] = '{
            {6'b100000, 3'd0, 8'b0000_0000},
            {6'b110101, 3'd1, 8'b1011_0001},
            {6'b010101, 3'd2, 8'b0000_0001},
            {6'b010101, 3'd3, 8'b0000_0001},
            {6'b010100, 3'd4, 8'b1000_0001},
            {6'b010100, 3'd4, 8'b1000_0001},
            {6'b010101, 3'd4, 8'b1000_0001},
            {6'b010100, 3'd5, 8'b0000_1101},
            {6'b000000, 3'd0, 8'b0000_0000}
        };
        logic [31:0] n0 = instret;
        for (int i = 0; i < 9; i++) begin
            {run, load, store, reg_write, illegal, mem_ready} = tbl[i][16:11];
            #1;
            total++;
            if (obs !== tbl[i][10:0]) begin
                bad++; $display("FAIL load row %0d: got %b want %b", i, obs, tbl[i][10:0]);
            end
            tick();
        end
        total++;
        if (instret !== n0 + 32'd1) begin
            bad++; $display("FAIL load_instret: got %0d want %0d", instret, n0 + 32'd1);
        end
    endtask

    task automatic test_store();
        logic [16:0] tbl [7] = '{
            {6'b100000, 3'd0, 8'b0000_0000},
            {6'b101001, 3'd1, 8'b1011_0001},
            {6'b101001, 3'd2, 8'b0000_0001},
            {6'b001000, 3'd3, 8'b0000_0001},
            {6'b001000, 3'd4, 8'b1100_0001},
            {6'b001101, 3'd4, 8'b1100_1001},
            {6'b000000, 3'd0, 8'b0000_0000}
        };
        logic [31:0] n0 = instret;
        for (int i = 0; i < 7; i++) begin
            {run, load, store, reg_write, illegal, mem_ready} = tbl[i][16:11];
            #1;
            total++;
            if (obs !== tbl[i][10:0]) begin
                bad++; $display("FAIL store row %0d: got %b want %b", i, obs, tbl[i][10:0]);
            end
            tick();
        end
        total++;
        if (instret !== n0 + 32'd1) begin
            bad++; $display("FAIL store_instret: got %0d want %0d", instret, n0 + 32'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] tbl [11] = '{
            {6'b100000, 3'd0, 8'b0000_0000},
            {6'b111101, 3'd1, 8'b1011_0001},
            {6'b111100, 3'd2, 8'b0000_0001},
            {6'b111100, 3'd3, 8'b0000_0001},
            {6'b111101, 3'd4, 8'b1100_1001},
            {6'b000000, 3'd1, 8'b1010_0001},
            {6'b000001, 3'd1, 8'b1011_0001},
            {6'b000000, 3'd2, 8'b0000_0001},
            {6'b000000, 3'd3, 8'b0000_0001},
            {6'b000000, 3'd5, 8'b0000_1001},
            {6'b000000, 3'd0, 8'b0000_0000}
        };
        logic [31:0] n0 = instret;
        for (int i = 0; i < 11; i++) begin
            {run, load, store, reg_write, illegal, mem_ready} = tbl[i][16:11];
            #1;
            total++;
            if (obs !== tbl[i][10:0]) begin
                bad++; $display("FAIL b2b row %0d: got %b want %b", i, obs, tbl[i][10:0]);
            end
            tick();
        end
        total++;
        if (instret !== n0 + 32'd2) begin
            bad++; $display("FAIL b2b_instret: got %0d want %0d", instret, n0 + 32'd2);
        end
    endtask

    task automatic test_wrap();
        {run, load, store, reg_write, illegal, mem_ready} = 6'b000000;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        {run, reg_write, mem_ready} = 3'b111;
        // one IDLE->FETCH edge, then 17 back-to-back 4-cycle ALU instructions
        repeat (69) tick();
        total++;
        if (instret4 !== 4'd1) begin
            bad++; $display("FAIL wrap_instret4: got %0d want 1", instret4);
        end
        total++;
        if (instret !== 32'd17) begin
            bad++; $display("FAIL wrap_instret32: got %0d want 17", instret);
        end
        {run, reg_write, mem_ready} = 3'b000;
        #1;
        total++;
        if (obs !== {3'd1, 8'b1010_0001}) begin
            bad++; $display("FAIL wrap_end_fetch: got %b want %b", obs, {3'd1, 8'b1010_0001});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        logic [16:0] tbl [4] = '{
            {6'b100000, 3'd0, 8'b0000_0000},
            {6'b100011, 3'd1, 8'b1011_0001},
            {6'b100010, 3'd2, 8'b0000_0001},
            {6'b100000, 3'd6, 8'b0000_0010}
        };
        logic [31:0] n0 = instret;
        for (int i = 0; i < 4; i++) begin
            {run, load, store, reg_write, illegal, mem_ready} = tbl[i][16:11];
            #1;
            total++;
            if (obs !== tbl[i][10:0]) begin
                bad++; $display("FAIL illegal row %0d: got %b want %b", i, obs, tbl[i][10:0]);
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            {run, load, store, reg_write, illegal, mem_ready} = 6'($urandom_range(0, 63));
            #1;
            total++;
            if (obs !== {3'd6, 8'b0000_0010} || instret !== n0) begin
                bad++;
                $display("FAIL trap_hold cycle %0d: got %b/%0d want %b/%0d",
                         i, obs, instret, {3'd6, 8'b0000_0010}, n0);
            end
            tick();
        end
        rst_n = 1'b0;
        run = 1'b1;
        tick();
        rst_n = 1'b1;
        run = 1'b0;
        #1;
        total++;
        if (obs !== 11'd0) begin
            bad++; $display("FAIL trap_cleared: got %b want %b", obs, 11'd0);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_wrap();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
